// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side consumer.
// Buffer depth and occupancy width are fixed by the 1-cycle pop latency.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W = 2;

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream of the FIFO reader.
// master drives words, slave applies backpressure.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry buffer absorbing the FIFO read latency.
// Push and pop may coincide; pop is only legal while valid.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  wr_idx;
  logic                  rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign valid = (occ != '0);
  assign data  = mem[rd_idx];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the synchronous FIFO and re-presents its words as a stream.
// Holds pop issue, the inflight flag and the transfer counter.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  fifo_stream_reader_if.master  strm,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  localparam int LVL_W = OCC_W + 1;

  occ_t             occ;
  logic             inflight;
  logic             pop_out;
  logic             buf_valid;
  logic [LVL_W-1:0] lvl;

  assign pop_out = buf_valid & strm.m_ready;

  // Words owed after this cycle; m_ready feeds this on purpose.
  assign lvl = {1'b0, occ}
             + LVL_W'(inflight)
             - LVL_W'(pop_out);

  assign fifo_r_en = !rst & en & !fifo_empty
                   & (lvl < LVL_W'(BUF_DEPTH));

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop_out),
    .valid     (buf_valid),
    .data      (strm.m_data),
    .occ       (occ)
  );

  assign strm.m_valid = buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (pop_out) begin
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader against a queue-based
// model of the FIFO and of word availability/order.
module tb_fifo_stream_reader;

  typedef struct {
    logic [7:0] d;
    int         avail;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data_out;
  logic       m_ready;
  logic       r_en1;
  logic       r_en2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) s1 ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) s2 ();

  assign s1.m_ready = m_ready;
  assign s2.m_ready = m_ready;

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_r_en     (r_en1),
    .strm          (s1),
    .xfer_cnt      (cnt1)
  );

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (4)
  ) dut4 (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_r_en     (r_en2),
    .strm          (s2),
    .xfer_cnt      (cnt2)
  );

  always #5 clk = ~clk;

  logic [7:0] fq[$];
  ent_t       sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dcnt = 0;
  bit known = 0;
  int npop, ndel, first_ren, last_ren, first_v, first_del;

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    npop = 0;
    ndel = 0;
    first_ren = -1;
    last_ren = -1;
    first_v = -1;
    first_del = -1;
  endtask

  task automatic push_word(logic [7:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic preload(logic [7:0] base, int n);
    for (int i = 0; i < n; i++) begin
      push_word(base + 8'(i));
    end
  endtask

  // One clock: check outputs at negedge, advance models after posedge.
  task automatic tick();
    bit exp_v, xfer, exp_ren, ren_s, rst_s;
    logic [7:0] w;
    @(negedge clk);
    exp_v = known && sb.size() > 0 && sb[0].avail <= cyc;
    xfer = exp_v && m_ready;
    exp_ren = !rst && en && fq.size() > 0
           && (sb.size() - int'(xfer)) < 2;
    chk("r_en", 32'(r_en1), 32'(exp_ren));
    chk("r_en_w4", 32'(r_en2), 32'(exp_ren));
    if (known) begin
      chk("valid", 32'(s1.m_valid), 32'(exp_v));
      chk("cnt", 32'(cnt1), 32'(dcnt % 65536));
      chk("cnt_w4", 32'(cnt2), 32'(dcnt % 16));
      if (exp_v) chk("data", 32'(s1.m_data), 32'(sb[0].d));
    end
    ren_s = r_en1;
    rst_s = rst;
    if (ren_s) begin
      npop++;
      if (first_ren < 0) first_ren = cyc;
      last_ren = cyc;
    end
    if (s1.m_valid && first_v < 0) first_v = cyc;
    if (xfer) begin
      if (first_del < 0) first_del = int'(sb[0].d);
      void'(sb.pop_front());
      dcnt++;
      ndel++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ren_s && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_data_out = w;
      sb.push_back('{w, cyc + 1});
    end
    if (rst_s) begin
      sb.delete();
      dcnt = 0;
      known = 1;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_data_out = 8'h00;
    clr_stats();

    // Reset with a non-empty FIFO and en high.
    preload(8'h11, 8);
    en = 1'b1;
    m_ready = 1'b1;
    do_reset(2);
    chk("rst_pops", 32'(npop), 32'd0);
    chk("rst_valid", 32'(s1.m_valid), 32'd0);
    chk("rst_cnt", 32'(cnt1), 32'd0);

    // Full-rate streaming.
    clr_stats();
    repeat (12) tick();
    chk("str_pops", 32'(npop), 32'd8);
    chk("str_consec", 32'(last_ren - first_ren + 1), 32'd8);
    chk("str_lat", 32'(first_v - first_ren), 32'd2);
    chk("str_del", 32'(ndel), 32'd8);
    chk("str_cnt", 32'(cnt1), 32'd8);

    // Backpressure then release.
    do_reset(1);
    preload(8'h11, 8);
    clr_stats();
    m_ready = 1'b0;
    repeat (6) tick();
    chk("bp_pops", 32'(npop), 32'd2);
    chk("bp_valid", 32'(s1.m_valid), 32'd1);
    chk("bp_hold", 32'(s1.m_data), 32'h11);
    m_ready = 1'b1;
    repeat (14) tick();
    chk("bp_del", 32'(ndel), 32'd8);
    chk("bp_first", 32'(first_del), 32'h11);

    // Random m_ready with the same ordering.
    do_reset(1);
    preload(8'h11, 8);
    clr_stats();
    repeat (60) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_del", 32'(ndel), 32'd8);

    // en falls one cycle after a pop.
    do_reset(1);
    preload(8'h21, 4);
    clr_stats();
    m_ready = 1'b0;
    tick();
    en = 1'b0;
    m_ready = 1'b1;
    repeat (8) tick();
    chk("en_pops", 32'(npop), 32'd1);
    chk("en_del", 32'(ndel), 32'd1);
    chk("en_word", 32'(first_del), 32'h21);

    // Empty FIFO: buffer drains, no pops.
    do_reset(1);
    fq.delete();
    fifo_empty = 1'b1;
    preload(8'h31, 2);
    en = 1'b1;
    m_ready = 1'b0;
    repeat (5) tick();
    clr_stats();
    m_ready = 1'b1;
    repeat (6) tick();
    chk("emp_pops", 32'(npop), 32'd0);
    chk("emp_del", 32'(ndel), 32'd2);
    chk("emp_valid", 32'(s1.m_valid), 32'd0);

    // Reset with words buffered and one inflight.
    do_reset(1);
    preload(8'h11, 8);
    m_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(s1.m_valid), 32'd0);
    chk("mrst_cnt", 32'(cnt1), 32'd0);
    clr_stats();
    m_ready = 1'b1;
    repeat (10) tick();
    chk("mrst_first", 32'(first_del), 32'h13);

    // Long random run: producer, en, ready and reset.
    do_reset(1);
    fq.delete();
    fifo_empty = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16)
        push_word(8'($urandom));
      en = ($urandom_range(0, 4) != 0);
      m_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    // Counter wrap on the narrow instance.
    do_reset(1);
    fq.delete();
    fifo_empty = 1'b1;
    preload(8'h40, 17);
    en = 1'b1;
    m_ready = 1'b1;
    repeat (24) tick();
    chk("wrap_w4", 32'(cnt2), 32'd1);
    chk("wrap_w16", 32'(cnt1), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
